// File: rtl/riscv_id_pkg.sv
// rtl/riscv_id_pkg.sv - shared RV32I decode constants and operand bundle type
package riscv_id_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

  // instr bit that turns ADD into SUB and SRL into SRA
  localparam int FUNCT7_ALT = 30;

  typedef enum logic [2:0] {
    FUNCT3_ADD  = 3'd0,
    FUNCT3_SLL  = 3'd1,
    FUNCT3_SLT  = 3'd2,
    FUNCT3_SLTU = 3'd3,
    FUNCT3_XOR  = 3'd4,
    FUNCT3_SRL  = 3'd5,
    FUNCT3_OR   = 3'd6,
    FUNCT3_AND  = 3'd7
  } funct3_e;

  typedef struct packed {
    logic [4:0]      rdi;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [5:0]      shamt;
    logic [2:0]      funct3;
    logic            invertb;
  } bundle_t;

  localparam bundle_t BUBBLE = '0;

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == FUNCT3_SLL) || (f3 == FUNCT3_SRL);
  endfunction
endpackage

// File: rtl/riscv_id_if.sv
// rtl/riscv_id_if.sv - instruction handshake, writeback and operand bundle bus
interface riscv_id_if;
  import riscv_id_pkg::*;

  logic [31:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_result;
  logic [4:0]      rdi;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [5:0]      shamt;
  logic [2:0]      funct3;
  logic            invertb;
  logic            illegal;

  modport master (
    output instr, instr_valid, wb_rd, wb_result,
    input  instr_ready, rdi, a, b, shamt, funct3, invertb, illegal
  );

  modport slave (
    input  instr, instr_valid, wb_rd, wb_result,
    output instr_ready, rdi, a, b, shamt, funct3, invertb, illegal
  );
endinterface

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - 32x32 register file, two async read ports, one sync write port
module riscv_regfile
  import riscv_id_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

// File: rtl/riscv_id.sv
// rtl/riscv_id.sv - RV32I decode/operand fetch with writeback bypass and 1-cycle RAW stall
module riscv_id
  import riscv_id_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  riscv_id_if.slave  bus
);
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] rf_rs1, rf_rs2, rs1_val, rs2_val, imm_i;
  logic            rs1_used, rs2_used, legal, hazard, accept;
  bundle_t         dec, q;
  logic            illegal_q;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign f3     = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};

  riscv_regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rs1),
    .rdata2 (rf_rs2),
    .waddr  (bus.wb_rd),
    .wdata  (bus.wb_result)
  );

  // Result being written this cycle wins over the not-yet-updated entry
  assign rs1_val = (rs1 != 5'd0 && rs1 == bus.wb_rd) ? bus.wb_result : rf_rs1;
  assign rs2_val = (rs2 != 5'd0 && rs2 == bus.wb_rd) ? bus.wb_result : rf_rs2;

  always_comb begin
    dec      = BUBBLE;
    legal    = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPCODE_OP: begin
        legal       = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        dec.rdi     = rd;
        dec.a       = rs1_val;
        dec.funct3  = f3;
        dec.invertb = bus.instr[FUNCT7_ALT] & ((f3 == FUNCT3_ADD) || (f3 == FUNCT3_SRL));
        if (is_shift(f3)) dec.shamt = {1'b0, rs2_val[4:0]};
        else              dec.b     = rs2_val;
      end
      OPCODE_OP_IMM: begin
        legal      = 1'b1;
        rs1_used   = 1'b1;
        dec.rdi    = rd;
        dec.a      = rs1_val;
        dec.funct3 = f3;
        if (is_shift(f3)) begin
          dec.shamt   = {1'b0, bus.instr[24:20]};
          dec.invertb = bus.instr[FUNCT7_ALT] & (f3 == FUNCT3_SRL);
        end else begin
          dec.b = imm_i;
        end
      end
      OPCODE_LUI: begin
        legal   = 1'b1;
        dec.rdi = rd;
        dec.b   = {bus.instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Only the instruction currently on the outputs can be unwritten; one bubble clears it
  assign hazard = bus.instr_valid && (q.rdi != 5'd0) &&
                  ((rs1_used && rs1 == q.rdi) || (rs2_used && rs2 == q.rdi));
  assign bus.instr_ready = !rst && !hazard;
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      q         <= (accept && legal) ? dec : BUBBLE;
      illegal_q <= accept && !legal;
    end
  end

  assign bus.rdi     = q.rdi;
  assign bus.a       = q.a;
  assign bus.b       = q.b;
  assign bus.shamt   = q.shamt;
  assign bus.funct3  = q.funct3;
  assign bus.invertb = q.invertb;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_riscv_id.sv
// tb/tb_riscv_id.sv - scoreboard bench for riscv_id with a behavioural execute stage in the loop
module tb_riscv_id;
  import riscv_id_pkg::*;

  logic clk = 1'b0;
  logic rst;

  riscv_id_if bus ();

  riscv_id dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rdi;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sh;
    logic [2:0]  f3;
    logic        inv;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
  } wb_t;

  exp_t bq[$];
  wb_t  wq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] rdi, input logic [31:0] a, input logic [31:0] b,
                              input logic [5:0] sh, input logic [2:0] f3, input logic inv,
                              input logic ill);
    exp_t e;
    e.rdi = rdi; e.a = a; e.b = b; e.sh = sh; e.f3 = f3; e.inv = inv; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [5:0] sh, input logic [2:0] f3, input logic inv);
    case (f3)
      3'd0:    return inv ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return inv ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Execute stage stand-in: consumes the bundle and returns result/rd one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_rd     <= '0;
      bus.wb_result <= '0;
    end else begin
      bus.wb_rd     <= bus.rdi;
      bus.wb_result <= alu(bus.a, bus.b, bus.shamt, bus.funct3, bus.invertb);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    wb_t  w;
    if (rst === 1'b0 && (bus.rdi != 5'd0 || bus.illegal)) begin
      if (bq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_bundle: rdi=%0d illegal=%0b, expected nothing pending", bus.rdi, bus.illegal);
      end else begin
        e = bq.pop_front();
        check("bundle_rdi",     {27'b0, bus.rdi},     {27'b0, e.rdi});
        check("bundle_a",       bus.a,                e.a);
        check("bundle_b",       bus.b,                e.b);
        check("bundle_shamt",   {26'b0, bus.shamt},   {26'b0, e.sh});
        check("bundle_funct3",  {29'b0, bus.funct3},  {29'b0, e.f3});
        check("bundle_invertb", {31'b0, bus.invertb}, {31'b0, e.inv});
        check("bundle_illegal", {31'b0, bus.illegal}, {31'b0, e.ill});
      end
    end
    if (rst === 1'b0 && bus.wb_rd != 5'd0) begin
      if (wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wb: rd=%0d result=0x%08h, expected nothing pending", bus.wb_rd, bus.wb_result);
      end else begin
        w = wq.pop_front();
        check("wb_rd",     {27'b0, bus.wb_rd}, {27'b0, w.rd});
        check("wb_result", bus.wb_result,      w.res);
      end
    end
  end

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input string name, input logic [31:0] ins, input int estall,
                      input exp_t e, input logic [31:0] eres);
    int  st;
    wb_t w;
    st = 0;
    if (e.rdi != 5'd0 || e.ill) bq.push_back(e);
    if (e.rdi != 5'd0) begin
      w.rd  = e.rdi;
      w.res = eres;
      wq.push_back(w);
    end
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    while (!bus.instr_ready && st < 4) begin
      st++;
      @(negedge clk);
      check({name, "_stall_bubble_rdi"}, {27'b0, bus.rdi}, 32'd0);
    end
    if (!bus.instr_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept_timeout: instr_ready still 0 after %0d cycles, expected 1", name, st);
      bus.instr_valid = 1'b0;
      return;
    end
    check({name, "_stalls"}, st, estall);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   {31'b0, bus.instr_ready}, 32'd0);
    check("rst_rdi",     {27'b0, bus.rdi},         32'd0);
    check("rst_a",       bus.a,                    32'd0);
    check("rst_b",       bus.b,                    32'd0);
    check("rst_shamt",   {26'b0, bus.shamt},       32'd0);
    check("rst_funct3",  {29'b0, bus.funct3},      32'd0);
    check("rst_invertb", {31'b0, bus.invertb},     32'd0);
    check("rst_illegal", {31'b0, bus.illegal},     32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    #1;

    // writeback through the register file after two bubbles
    send("addi_x1",   32'h02800093, 0, mk(5'd1, 32'd0, 32'd40, 6'd0, 3'd0, 1'b0, 1'b0), 32'd40);
    idle(2);
    send("addi_x2",   32'h00208113, 0, mk(5'd2, 32'd40, 32'd2, 6'd0, 3'd0, 1'b0, 1'b0), 32'd42);

    // back-to-back RAW on both sources
    send("addi_x1b",  32'h02800093, 0, mk(5'd1, 32'd0, 32'd40, 6'd0, 3'd0, 1'b0, 1'b0), 32'd40);
    send("sub_x3",    32'h401081B3, 1, mk(5'd3, 32'd40, 32'd40, 6'd0, 3'd0, 1'b1, 1'b0), 32'd0);

    // shifts, immediate and register forms
    send("addi_x5",   32'h00300293, 0, mk(5'd5, 32'd0, 32'd3, 6'd0, 3'd0, 1'b0, 1'b0), 32'd3);
    send("slli_x6",   32'h00229313, 1, mk(5'd6, 32'd3, 32'd0, 6'd2, 3'd1, 1'b0, 1'b0), 32'd12);
    send("addi_x7",   32'hFF800393, 0, mk(5'd7, 32'd0, 32'hFFFFFFF8, 6'd0, 3'd0, 1'b0, 1'b0), 32'hFFFFFFF8);
    send("srai_x9",   32'h4013D493, 1, mk(5'd9, 32'hFFFFFFF8, 32'd0, 6'd1, 3'd5, 1'b1, 1'b0), 32'hFFFFFFFC);
    send("sra_x10",   32'h4053D533, 0, mk(5'd10, 32'hFFFFFFF8, 32'd0, 6'd3, 3'd5, 1'b1, 1'b0), 32'hFFFFFFFF);
    send("add_x11",   32'h005085B3, 0, mk(5'd11, 32'd40, 32'd3, 6'd0, 3'd0, 1'b0, 1'b0), 32'd43);

    // LUI, then rd=x0 whose result must neither land nor bypass
    send("lui_x4",    32'h12345237, 0, mk(5'd4, 32'd0, 32'h12345000, 6'd0, 3'd0, 1'b0, 1'b0), 32'h12345000);
    send("addi_x0",   32'h00900013, 0, mk(5'd0, 32'd0, 32'd0, 6'd0, 3'd0, 1'b0, 1'b0), 32'd0);
    idle(1);
    send("add_x8",    32'h00000433, 0, mk(5'd8, 32'd0, 32'd0, 6'd0, 3'd0, 1'b0, 1'b0), 32'd0);

    // unsupported opcode
    send("branch",    32'h00000063, 0, mk(5'd0, 32'd0, 32'd0, 6'd0, 3'd0, 1'b0, 1'b1), 32'd0);
    idle(1);

    // reset arrives while a dependent instruction is stalled
    bq.push_back(mk(5'd12, 32'd0, 32'd5, 6'd0, 3'd0, 1'b0, 1'b0));
    bus.instr       = 32'h00500613;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    check("x12_ready", {31'b0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    #1 bus.instr = 32'h00C606B3;
    @(negedge clk);
    check("stall_before_rst", {31'b0, bus.instr_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("ready_in_rst", {31'b0, bus.instr_ready}, 32'd0);
    @(negedge clk);
    check("midrst_rdi",     {27'b0, bus.rdi},     32'd0);
    check("midrst_a",       bus.a,                32'd0);
    check("midrst_b",       bus.b,                32'd0);
    check("midrst_funct3",  {29'b0, bus.funct3},  32'd0);
    check("midrst_invertb", {31'b0, bus.invertb}, 32'd0);
    check("midrst_ready",   {31'b0, bus.instr_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", {31'b0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    send("add_x14",   32'h00508733, 0, mk(5'd14, 32'd0, 32'd0, 6'd0, 3'd0, 1'b0, 1'b0), 32'd0);

    idle(4);
    check("bundle_queue_drained", bq.size(), 32'd0);
    check("wb_queue_drained",     wq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
